// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard for an in-order EX/MEM/WB pipeline.
// Each architectural register has a valid bit, a load bit and an age.
// Together with the branch/jump mispredict checks, these produce the
// stall and flush controls combinationally. Saturating counters
// record how many cycles the pipeline stalled and how many it flushed.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 4,
    parameter int REG_AW      = 2,
    parameter int NUM_SRC     = 2,
    parameter int FWD_EN      = 1,
    parameter int RF_SELF_FWD = 1,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic                      id_dst_valid,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_dst_is_load,
    input  logic                      mem_stall,
    input  logic                      ex_is_branch,
    input  logic [15:0]               ex_correct_pc,
    input  logic [15:0]               id_pc,
    input  logic                      id_is_jump,
    input  logic [15:0]               id_correct_pc,
    input  logic [15:0]               if_pc,
    output logic                      stall,
    output logic                      flush_ifid,
    output logic                      flush_idex,
    output logic                      branch_failed,
    output logic                      jump_failed,
    output logic [NUM_REGS-1:0]       pending,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    // Age of the producer: which stage it will be in during the next cycle.
    localparam logic [1:0] AGE_EX  = 2'd1;
    localparam logic [1:0] AGE_MEM = 2'd2;
    localparam logic [1:0] AGE_WB  = 2'd3;

    logic [NUM_REGS-1:0] v_q, v_d;
    logic [NUM_REGS-1:0] l_q, l_d;
    logic [1:0]          a_q [NUM_REGS];
    logic [1:0]          a_d [NUM_REGS];
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic                data_hazard;
    logic                issue;
    logic [REG_AW-1:0]   src_addr;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction

    // Decides whether a live producer entry blocks a reader this cycle.
    // With forwarding, only a load still in EX cannot be bypassed.
    // Without it, the result is usable only once it has reached WB, and
    // even then only if the register file bypasses the same-cycle write.
    function automatic logic entry_blocks(input logic is_load, input logic [1:0] age);
        if (FWD_EN != 0) begin
            return is_load && (age == AGE_EX);
        end
        return (age == AGE_EX) || (age == AGE_MEM) ||
               ((age == AGE_WB) && (RF_SELF_FWD == 0));
    endfunction

    // Looks up each used source operand in the scoreboard.
    always_comb begin
        data_hazard = 1'b0;
        src_addr    = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src_addr = id_src_addr[s*REG_AW +: REG_AW];
            if (id_valid && id_src_used[s] && (int'(src_addr) < NUM_REGS)) begin
                if (v_q[src_addr] && entry_blocks(l_q[src_addr], a_q[src_addr])) begin
                    data_hazard = 1'b1;
                end
            end
        end
    end

    // Mispredict detection and stall/flush combination. A failed branch
    // in EX wins over everything younger, so a hazard behind it neither
    // stalls nor issues.
    always_comb begin
        branch_failed = ex_is_branch && (ex_correct_pc != id_pc) && !mem_stall;
        jump_failed   = id_valid && id_is_jump && (id_correct_pc != if_pc) &&
                        !branch_failed && !mem_stall;
        stall         = mem_stall || (data_hazard && !branch_failed);
        flush_ifid    = branch_failed || jump_failed;
        flush_idex    = branch_failed || (data_hazard && !mem_stall);
        issue         = id_valid && id_dst_valid && !stall && !branch_failed && !mem_stall;
    end

    // Next scoreboard state. A new writer overrides both the aging and the
    // retirement of an older entry for the same register.
    always_comb begin
        v_d = v_q;
        l_d = l_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            a_d[r] = a_q[r];
            if (issue && (id_dst_addr == REG_AW'(r))) begin
                v_d[r] = 1'b1;
                l_d[r] = id_dst_is_load;
                a_d[r] = AGE_EX;
            end else if (!mem_stall && v_q[r]) begin
                case (a_q[r])
                    AGE_EX:  a_d[r] = AGE_MEM;
                    AGE_MEM: a_d[r] = AGE_WB;
                    default: begin
                        v_d[r] = 1'b0;
                        l_d[r] = 1'b0;
                        a_d[r] = 2'd0;
                    end
                endcase
            end
        end
    end

    // Next values of the statistics counters.
    always_comb begin
        stall_cnt_d = stall      ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = flush_ifid ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    // State registers. Reset drops every in-flight entry and the statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q         <= '0;
            l_q         <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                a_q[r] <= 2'd0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            v_q         <= v_d;
            l_q         <= l_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                a_q[r] <= a_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign pending   = v_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. Two builds share the same stimulus:
// build A uses full forwarding and 16-bit counters; build B has no
// forwarding, no register-file bypass and 4-bit counters. The reference
// models the pipeline as a three-slot EX/MEM/WB shift register of
// in-flight writers, not as per-register state.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        id_valid;
    logic [1:0]  id_src_used;
    logic [3:0]  id_src_addr;
    logic        id_dst_valid;
    logic [1:0]  id_dst_addr;
    logic        id_dst_is_load;
    logic        mem_stall;
    logic        ex_is_branch;
    logic [15:0] ex_correct_pc, id_pc, id_correct_pc, if_pc;
    logic        id_is_jump;

    logic        a_stall, a_fifd, a_fidex, a_bf, a_jf;
    logic [3:0]  a_pend;
    logic [15:0] a_scnt, a_fcnt;
    logic        b_stall, b_fifd, b_fidex, b_bf, b_jf;
    logic [3:0]  b_pend;
    logic [3:0]  b_scnt, b_fcnt;

    hazard_scoreboard #(.NUM_REGS(4), .REG_AW(2), .NUM_SRC(2), .FWD_EN(1),
                        .RF_SELF_FWD(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_used(id_src_used),
        .id_src_addr(id_src_addr), .id_dst_valid(id_dst_valid), .id_dst_addr(id_dst_addr),
        .id_dst_is_load(id_dst_is_load), .mem_stall(mem_stall), .ex_is_branch(ex_is_branch),
        .ex_correct_pc(ex_correct_pc), .id_pc(id_pc), .id_is_jump(id_is_jump),
        .id_correct_pc(id_correct_pc), .if_pc(if_pc), .stall(a_stall), .flush_ifid(a_fifd),
        .flush_idex(a_fidex), .branch_failed(a_bf), .jump_failed(a_jf), .pending(a_pend),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

    hazard_scoreboard #(.NUM_REGS(4), .REG_AW(2), .NUM_SRC(2), .FWD_EN(0),
                        .RF_SELF_FWD(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_used(id_src_used),
        .id_src_addr(id_src_addr), .id_dst_valid(id_dst_valid), .id_dst_addr(id_dst_addr),
        .id_dst_is_load(id_dst_is_load), .mem_stall(mem_stall), .ex_is_branch(ex_is_branch),
        .ex_correct_pc(ex_correct_pc), .id_pc(id_pc), .id_is_jump(id_is_jump),
        .id_correct_pc(id_correct_pc), .if_pc(if_pc), .stall(b_stall), .flush_ifid(b_fifd),
        .flush_idex(b_fidex), .branch_failed(b_bf), .jump_failed(b_jf), .pending(b_pend),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference pipeline per build: slot 0 = EX, 1 = MEM, 2 = WB.
    logic       mv [2][3];
    logic [1:0] md [2][3];
    logic       ml [2][3];
    int         mcs [2];
    int         mcf [2];

    typedef struct packed {
        logic       stall;
        logic       fifd;
        logic       fidex;
        logic       bf;
        logic       jf;
        logic       issue;
        logic [3:0] pend;
    } exp_t;

    function automatic int cnt_max(input int c);
        return (c == 0) ? 65535 : 15;
    endfunction

    function automatic exp_t model_out(input int c);
        exp_t       e;
        logic       hz;
        logic [1:0] a;
        hz = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (id_valid && id_src_used[s]) begin
                a = id_src_addr[s*2 +: 2];
                for (int k = 0; k < 3; k++) begin
                    if (mv[c][k] && md[c][k] == a) begin
                        // Build A: only a load still in EX is unbypassable.
                        // Build B: value unusable until it has left WB.
                        if (c == 0) hz = hz | (k == 0 && ml[c][k]);
                        else        hz = 1'b1;
                    end
                end
            end
        end
        e.bf    = ex_is_branch && (ex_correct_pc != id_pc) && !mem_stall;
        e.jf    = id_valid && id_is_jump && (id_correct_pc != if_pc) && !e.bf && !mem_stall;
        e.stall = mem_stall || (hz && !e.bf);
        e.fifd  = e.bf || e.jf;
        e.fidex = e.bf || (hz && !mem_stall);
        e.issue = id_valid && id_dst_valid && !e.stall && !e.bf && !mem_stall;
        e.pend  = 4'b0;
        for (int k = 0; k < 3; k++) begin
            if (mv[c][k]) e.pend[md[c][k]] = 1'b1;
        end
        return e;
    endfunction

    // Reference state advance: shift the pipeline unless memory is stalled.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 3; k++) begin
                    mv[c][k] <= 1'b0;
                    md[c][k] <= 2'd0;
                    ml[c][k] <= 1'b0;
                end
                mcs[c] <= 0;
                mcf[c] <= 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                exp_t e;
                e = model_out(c);
                if (e.stall && mcs[c] < cnt_max(c)) mcs[c] <= mcs[c] + 1;
                if (e.fifd  && mcf[c] < cnt_max(c)) mcf[c] <= mcf[c] + 1;
                if (!mem_stall) begin
                    for (int k = 2; k > 0; k--) begin
                        mv[c][k] <= mv[c][k-1];
                        md[c][k] <= md[c][k-1];
                        ml[c][k] <= ml[c][k-1];
                    end
                    mv[c][0] <= e.issue;
                    md[c][0] <= id_dst_addr;
                    ml[c][0] <= id_dst_is_load;
                end
            end
        end
    end

    // Every-cycle comparison of both builds against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t ea, eb;
            ea = model_out(0);
            eb = model_out(1);
            chk("a_stall",  32'(a_stall), 32'(ea.stall));
            chk("a_fifd",   32'(a_fifd),  32'(ea.fifd));
            chk("a_fidex",  32'(a_fidex), 32'(ea.fidex));
            chk("a_bf",     32'(a_bf),    32'(ea.bf));
            chk("a_jf",     32'(a_jf),    32'(ea.jf));
            chk("a_pend",   32'(a_pend),  32'(ea.pend));
            chk("a_scnt",   32'(a_scnt),  32'(mcs[0]));
            chk("a_fcnt",   32'(a_fcnt),  32'(mcf[0]));
            chk("b_stall",  32'(b_stall), 32'(eb.stall));
            chk("b_fifd",   32'(b_fifd),  32'(eb.fifd));
            chk("b_fidex",  32'(b_fidex), 32'(eb.fidex));
            chk("b_bf",     32'(b_bf),    32'(eb.bf));
            chk("b_jf",     32'(b_jf),    32'(eb.jf));
            chk("b_pend",   32'(b_pend),  32'(eb.pend));
            chk("b_scnt",   32'(b_scnt),  32'(mcs[1]));
            chk("b_fcnt",   32'(b_fcnt),  32'(mcf[1]));
        end
    end

    task automatic idle_inputs();
        id_valid = 1'b0; id_src_used = 2'b00; id_src_addr = 4'h0;
        id_dst_valid = 1'b0; id_dst_addr = 2'd0; id_dst_is_load = 1'b0;
        mem_stall = 1'b0; ex_is_branch = 1'b0; id_is_jump = 1'b0;
        ex_correct_pc = 16'h0; id_pc = 16'h0; id_correct_pc = 16'h0; if_pc = 16'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        chk_en = 1'b1;
        #1;
        chk("rst_a_pend", 32'(a_pend), 32'h0);
        chk("rst_a_scnt", 32'(a_scnt), 32'h0);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("idle_a_stall", 32'(a_stall), 32'h0);
        chk("idle_a_fifd",  32'(a_fifd),  32'h0);
        chk("idle_a_fidex", 32'(a_fidex), 32'h0);

        // Load to r1 followed by a reader of r1.
        next_cycle();
        id_valid = 1'b1; id_dst_valid = 1'b1; id_dst_addr = 2'd1; id_dst_is_load = 1'b1;
        next_cycle();
        id_dst_valid = 1'b0; id_dst_is_load = 1'b0; id_src_used = 2'b01; id_src_addr = 4'b0001;
        #1;
        chk("lwd_a_stall", 32'(a_stall), 32'h1);
        chk("lwd_a_fidex", 32'(a_fidex), 32'h1);
        chk("lwd_a_pend1", 32'(a_pend[1]), 32'h1);
        next_cycle();
        #1;
        chk("lwd_a_stall_after", 32'(a_stall), 32'h0);
        chk("lwd_b_stall_after", 32'(b_stall), 32'h1);
        idle_inputs();
        repeat (5) next_cycle();

        // Branch mispredict with a jump mismatch and a load-use hazard behind it.
        id_valid = 1'b1; id_dst_valid = 1'b1; id_dst_addr = 2'd3; id_dst_is_load = 1'b1;
        next_cycle();
        id_dst_addr = 2'd2; id_dst_is_load = 1'b0; id_src_used = 2'b01; id_src_addr = 4'b0011;
        ex_is_branch = 1'b1; ex_correct_pc = 16'h0010; id_pc = 16'h0011;
        id_is_jump = 1'b1; id_correct_pc = 16'h0020; if_pc = 16'h0024;
        #1;
        chk("br_a_bf",    32'(a_bf),    32'h1);
        chk("br_a_jf",    32'(a_jf),    32'h0);
        chk("br_a_stall", 32'(a_stall), 32'h0);
        chk("br_a_fifd",  32'(a_fifd),  32'h1);
        chk("br_a_fidex", 32'(a_fidex), 32'h1);
        next_cycle();
        idle_inputs();
        #1;
        chk("br_a_pend", 32'(a_pend), 32'h8);
        repeat (5) next_cycle();

        // Long memory stall saturates the 4-bit counter, then a reset pulse.
        mem_stall = 1'b1;
        repeat (21) next_cycle();
        chk("sat_b_scnt", 32'(b_scnt), 32'hF);
        mem_stall = 1'b0;
        id_valid = 1'b1; id_dst_valid = 1'b1; id_dst_addr = 2'd0;
        next_cycle();
        reset = 1'b1;
        idle_inputs();
        #1;
        chk("rst2_a_pend", 32'(a_pend), 32'h0);
        chk("rst2_b_pend", 32'(b_pend), 32'h0);
        chk("rst2_b_scnt", 32'(b_scnt), 32'h0);
        chk("rst2_a_scnt", 32'(a_scnt), 32'h0);
        next_cycle();
        reset = 1'b0;

        // Randomized traffic.
        repeat (3000) begin
            next_cycle();
            reset          = ($urandom_range(0, 199) == 0);
            id_valid       = ($urandom_range(0, 3) != 0);
            id_src_used    = 2'($urandom_range(0, 3));
            id_src_addr    = 4'($urandom_range(0, 15));
            id_dst_valid   = ($urandom_range(0, 2) != 0);
            id_dst_addr    = 2'($urandom_range(0, 3));
            id_dst_is_load = ($urandom_range(0, 1) != 0);
            mem_stall      = ($urandom_range(0, 7) == 0);
            ex_is_branch   = ($urandom_range(0, 5) == 0);
            ex_correct_pc  = 16'($urandom_range(0, 3));
            id_pc          = 16'($urandom_range(0, 3));
            id_is_jump     = ($urandom_range(0, 5) == 0);
            id_correct_pc  = 16'($urandom_range(0, 3));
            if_pc          = 16'($urandom_range(0, 3));
        end
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of architectural registers tracked.
REQ-002 SHALL have parameter REG_AW, default 2, register address width (2**REG_AW >= NUM_REGS).
REQ-003 SHALL have parameter NUM_SRC, default 2, number of ID-stage source operand ports.
REQ-004 SHALL have parameter FWD_EN, default 1, 1 = full forwarding present, 0 = no forwarding.
REQ-005 SHALL have parameter RF_SELF_FWD, default 1, 1 = register file forwards WB write to same-cycle read.
REQ-006 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-007 SHALL have ports: clk  in  1  clock, all state on rising edge; reset  in  1  asynchronous, active-high.
REQ-008 SHALL have ports: id_valid  in  1  ID holds a live instruction; id_src_used  in  NUM_SRC  per-source use flag; id_src_addr  in  NUM_SRC*REG_AW  packed source addresses, source 0 in LSBs.
REQ-009 SHALL have ports: id_dst_valid  in  1  ID instruction writes a register; id_dst_addr  in  REG_AW  destination; id_dst_is_load  in  1  destination written by LWD.
REQ-010 SHALL have ports: mem_stall  in  1  memory stage not ready (cache miss), whole pipeline frozen.
REQ-011 SHALL have ports: ex_is_branch  in  1; ex_correct_pc  in  16; id_pc  in  16; id_is_jump  in  1 (JMP/JAL/JPR/JRL); id_correct_pc  in  16; if_pc  in  16.
REQ-012 SHALL have outputs: stall  1; flush_ifid  1; flush_idex  1; branch_failed  1; jump_failed  1; pending  NUM_REGS  scoreboard valid bits; stall_cnt  CNT_W; flush_cnt  CNT_W.

Function
REQ-013 SHALL keep per register r: valid bit V[r], load bit L[r], 2-bit age A[r] (1=EX, 2=MEM, 3=WB).
REQ-014 SHALL define issue = id_valid & id_dst_valid & ~stall & ~branch_failed & ~mem_stall.
REQ-015 SHALL, on issue, set V[dst]=1, L[dst]=id_dst_is_load, A[dst]=1 at the next edge, overwriting any older entry for dst.
REQ-016 SHALL, when mem_stall=0, advance each valid entry not being set: A 1->2, 2->3, 3->cleared (V=0); when mem_stall=1, hold all entries unchanged.
REQ-017 SHALL give a set on the same edge as a clear of the same register priority to the set.
REQ-018 SHALL flag source s hazardous only if id_valid & id_src_used[s] & V[addr_s].
REQ-019 SHALL, with FWD_EN=0, flag hazard when A in {1,2}, or A=3 and RF_SELF_FWD=0.
REQ-020 SHALL, with FWD_EN=1, flag hazard only when L=1 and A=1.
REQ-021 SHALL compute branch_failed = ex_is_branch & (ex_correct_pc != id_pc) & ~mem_stall.
REQ-022 SHALL compute jump_failed = id_valid & id_is_jump & (id_correct_pc != if_pc) & ~branch_failed & ~mem_stall.
REQ-023 SHALL compute stall = mem_stall | (data_hazard & ~branch_failed).
REQ-024 SHALL compute flush_ifid = branch_failed | jump_failed; flush_idex = branch_failed | (data_hazard & ~mem_stall).
REQ-025 SHALL drive all control outputs combinationally in the same cycle as their inputs (zero latency).
REQ-026 SHALL increment stall_cnt each cycle stall=1 and flush_cnt each cycle flush_ifid=1, each saturating at all-ones.
REQ-027 SHALL ignore the jump's own destination for hazard purposes: a jump with id_dst_valid issues normally when not stalled.

Reset
REQ-028 SHALL, while reset=1, asynchronously clear all V, L, A, stall_cnt, flush_cnt; pending reads 0.
REQ-029 SHALL, after reset release, produce stall=0, flush outputs 0 when id_valid=0, ex_is_branch=0, mem_stall=0.
REQ-030 SHALL, on reset mid-operation, discard all in-flight entries; no hazard is reported for them afterwards.

Verification
REQ-031 FWD_EN=1: issue LWD to r1; next cycle ID reads r1 -> stall=1, flush_idex=1 one cycle; following cycle stall=0.
REQ-032 FWD_EN=0, RF_SELF_FWD=0: ADD to r2 issued; ID reads r2 -> stall=1 for 3 cycles, then 0; pending[2] clears after A=3.
REQ-033 LWD to r3 then mem_stall=1 for 4 cycles -> A[3] frozen at 1, stall=1 all 4 cycles, stall_cnt +4 plus hazard cycle.
REQ-034 ex_is_branch=1, ex_correct_pc=0x0010, id_pc=0x0011, id_is_jump=1 mismatching, data hazard present -> branch_failed=1, jump_failed=0, stall=0, both flushes=1, no scoreboard set.
REQ-035 Back-to-back writers to r0 (ADD then LWD) -> entry overwritten, L[0]=1, A[0]=1; same-edge clear vs set keeps V[0]=1.
REQ-036 Force stall for 2**CNT_W+5 cycles (CNT_W=4 build) -> stall_cnt holds 0xF; reset pulse mid-run -> counters and pending return to 0 immediately.
